// File: rtl/tv80_bus_pkg.sv
// Shared types and constants for the tv80s bus responder.
package tv80_bus_pkg;

  localparam int CNT_W = 8;
  localparam logic [7:0] BUS_FLOAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAITCNT,
    DONE
  } bus_state_t;

  function automatic logic [CNT_W-1:0] satDec(input logic [CNT_W-1:0] value);
    return (value == '0) ? value : value - 1'b1;
  endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// Combinational decode of the tv80s bus strobes into a cycle classification.
module z80_cycle_decode (
  input  logic i_m1_n,
  input  logic i_mreq_n,
  input  logic i_iorq_n,
  input  logic i_rd_n,
  input  logic i_wr_n,
  input  logic i_rfsh_n,
  output logic o_access,
  output logic o_intack,
  output logic o_is_io,
  output logic o_is_write
);

  // Refresh drives mreq_n low with rfsh_n low; it must never look like an access.
  assign o_access   = ((~i_mreq_n & i_rfsh_n) | ~i_iorq_n) & (~i_rd_n | ~i_wr_n);
  assign o_intack   = ~i_m1_n & ~i_iorq_n;
  assign o_is_io    = ~i_iorq_n;
  assign o_is_write = ~i_wr_n;

endmodule

// File: rtl/z80_bus_target.sv
// tv80s bus responder: turns each CPU bus cycle into one req/ack backend
// transaction and holds the CPU in wait until the backend answers.
module z80_bus_target
  import tv80_bus_pkg::*;
#(
  parameter int         MEM_WAIT    = 0,
  parameter int         IO_WAIT     = 1,
  parameter int         ACK_TIMEOUT = 15,
  parameter logic [7:0] INT_VECTOR  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic        be_ack,
  input  logic [7:0]  be_rdata,
  output logic        err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MEM_CNT  = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] IO_CNT   = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(ACK_TIMEOUT);

  logic w_access, w_intack, w_isIo, w_isWrite;
  logic [CNT_W-1:0] w_toNext;

  bus_state_t       r_state;
  logic [CNT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0] r_toCnt;
  logic [7:0]       r_cpuDi;
  logic             r_waitN;
  logic             r_beReq;
  logic             r_beWe;
  logic             r_beIo;
  logic [15:0]      r_beAddr;
  logic [7:0]       r_beWdata;
  logic             r_err;

  z80_cycle_decode u_decode (
    .i_m1_n     (m1_n),
    .i_mreq_n   (mreq_n),
    .i_iorq_n   (iorq_n),
    .i_rd_n     (rd_n),
    .i_wr_n     (wr_n),
    .i_rfsh_n   (rfsh_n),
    .o_access   (w_access),
    .o_intack   (w_intack),
    .o_is_io    (w_isIo),
    .o_is_write (w_isWrite)
  );

  assign w_toNext = r_toCnt + 1'b1;

  // Ack wins over a timeout landing on the same edge; DONE blocks re-triggering
  // until the CPU lets go, so one bus cycle makes exactly one request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_toCnt   <= '0;
      r_cpuDi   <= BUS_FLOAT;
      r_waitN   <= 1'b1;
      r_beReq   <= 1'b0;
      r_beWe    <= 1'b0;
      r_beIo    <= 1'b0;
      r_beAddr  <= '0;
      r_beWdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_intack) begin
            r_cpuDi   <= INT_VECTOR;
            r_waitN   <= (IO_WAIT == 0);
            r_waitCnt <= IO_CNT;
            r_toCnt   <= '0;
            r_state   <= WAITCNT;
          end else if (w_access) begin
            r_beAddr  <= A;
            r_beWe    <= w_isWrite;
            r_beIo    <= w_isIo;
            r_beWdata <= cpu_dout;
            r_beReq   <= 1'b1;
            r_waitN   <= 1'b0;
            r_waitCnt <= w_isIo ? IO_CNT : MEM_CNT;
            r_toCnt   <= '0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          r_waitCnt <= satDec(r_waitCnt);
          r_toCnt   <= w_toNext;
          if (be_ack) begin
            r_beReq <= 1'b0;
            if (!r_beWe) r_cpuDi <= be_rdata;
            r_state <= WAITCNT;
          end else if (w_toNext == TO_LIMIT) begin
            r_beReq <= 1'b0;
            r_cpuDi <= BUS_FLOAT;
            r_err   <= 1'b1;
            r_state <= WAITCNT;
          end
        end
        WAITCNT: begin
          if (r_waitCnt == '0) begin
            r_waitN <= 1'b1;
            r_state <= DONE;
          end else begin
            r_waitCnt <= satDec(r_waitCnt);
          end
        end
        DONE: begin
          if ((rd_n & wr_n) | (mreq_n & iorq_n)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_di   = r_cpuDi;
  assign wait_n   = r_waitN;
  assign be_req   = r_beReq;
  assign be_we    = r_beWe;
  assign be_io    = r_beIo;
  assign be_addr  = r_beAddr;
  assign be_wdata = r_beWdata;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_z80_bus_target.sv
// Self-checking bench: a CPU-side driver pushes expected backend transactions,
// a backend model pops and checks them when be_req rises.
module tb_z80_bus_target;

  localparam int         MEM_WAIT    = 0;
  localparam int         IO_WAIT     = 1;
  localparam int         ACK_TIMEOUT = 15;
  localparam logic [7:0] INT_VECTOR  = 8'hE7;

  localparam int K_MEMRD  = 0;
  localparam int K_MEMWR  = 1;
  localparam int K_IORD   = 2;
  localparam int K_IOWR   = 3;
  localparam int K_INTACK = 4;
  localparam int K_FETCH  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic [15:0] A = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_di;
  logic        wait_n, be_req, be_we, be_io, err, busy;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic        be_ack = 1'b0;
  logic [7:0]  be_rdata = '0;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic        io;
    logic [7:0]  wdata;
  } tx_t;

  tx_t expQ[$];
  tx_t curTx = '0;

  int errCount = 0, checkCount = 0;
  int reqCycles = 0, reqCount = 0, reqHigh = 0, strayDone = 0;
  int beAckDelay = 1, strayReq = 0;
  bit beNoAck = 1'b0;
  logic [7:0] beRdata = '0;
  logic [7:0] mDi = 8'hFF;

  always #5 clk = ~clk;

  z80_bus_target #(
    .MEM_WAIT    (MEM_WAIT),
    .IO_WAIT     (IO_WAIT),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .INT_VECTOR  (INT_VECTOR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m1_n     (m1_n),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .rfsh_n   (rfsh_n),
    .A        (A),
    .cpu_dout (cpu_dout),
    .cpu_di   (cpu_di),
    .wait_n   (wait_n),
    .be_req   (be_req),
    .be_we    (be_we),
    .be_io    (be_io),
    .be_addr  (be_addr),
    .be_wdata (be_wdata),
    .be_ack   (be_ack),
    .be_rdata (be_rdata),
    .err      (err),
    .busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Backend model: checks the latched request against the scoreboard and acks
  // so that the ack is seen on the beAckDelay-th REQ edge.
  always @(negedge clk) begin
    be_ack = 1'b0;
    if (be_req) begin
      reqCycles++;
      reqHigh++;
      if (reqCycles == 1) begin
        reqCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedReq", 32'(be_addr), 32'hFFFF_FFFF);
        end else begin
          curTx = expQ.pop_front();
          checkOutput("reqAddr", 32'(be_addr), 32'(curTx.addr));
          checkOutput("reqWe", 32'(be_we), 32'(curTx.we));
          checkOutput("reqIo", 32'(be_io), 32'(curTx.io));
          checkOutput("reqWdata", 32'(be_wdata), 32'(curTx.wdata));
        end
      end
      if (!beNoAck && reqCycles == beAckDelay) begin
        checkOutput("addrHeld", 32'(be_addr), 32'(curTx.addr));
        be_ack   = 1'b1;
        be_rdata = beRdata;
      end
    end else begin
      reqCycles = 0;
      if (strayReq != strayDone) begin
        be_ack    = 1'b1;
        be_rdata  = beRdata;
        strayDone = strayReq;
      end
    end
  end

  task automatic releaseBus();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // ackDelay = 0 means the backend never answers.
  task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [7:0] wdata,
                               input int ackDelay, input logic [7:0] rdata, input string tag);
    int waitLow = 0, errPulses = 0, highStart, edges, w, expLow;
    bit seenLow = 1'b0, finished = 1'b0;
    bit isAcc, isIo, isWr;
    isAcc = (kind != K_INTACK);
    isIo  = (kind == K_IORD) || (kind == K_IOWR);
    isWr  = (kind == K_MEMWR) || (kind == K_IOWR);
    @(negedge clk);
    beAckDelay = ackDelay;
    beNoAck    = (ackDelay == 0);
    beRdata    = rdata;
    highStart  = reqHigh;
    m1_n     = !((kind == K_FETCH) || (kind == K_INTACK));
    mreq_n   = !((kind == K_MEMRD) || (kind == K_MEMWR) || (kind == K_FETCH));
    iorq_n   = !(isIo || (kind == K_INTACK));
    rd_n     = !(isAcc && !isWr);
    wr_n     = !isWr;
    rfsh_n   = 1'b1;
    A        = addr;
    cpu_dout = wdata;
    if (isAcc) expQ.push_back('{addr: addr, we: isWr, io: isIo, wdata: wdata});

    w     = (isIo || !isAcc) ? IO_WAIT : MEM_WAIT;
    edges = beNoAck ? ACK_TIMEOUT : ackDelay;
    if (!isAcc) expLow = (w == 0) ? 0 : w + 1;
    else        expLow = edges + ((w > edges) ? w - edges : 0) + 1;
    if (!isAcc)       mDi = INT_VECTOR;
    else if (beNoAck) mDi = 8'hFF;
    else if (!isWr)   mDi = rdata;

    for (int i = 0; i < 80 && !finished; i++) begin
      @(negedge clk);
      if (err) errPulses++;
      if (!wait_n) begin
        waitLow++;
        seenLow = 1'b1;
      end else if (seenLow) begin
        finished = 1'b1;
      end
    end
    checkOutput({tag, " finished"}, 32'(finished), 32'd1);
    checkOutput({tag, " waitLow"}, waitLow, expLow);
    checkOutput({tag, " errPulses"}, errPulses, (isAcc && beNoAck) ? 1 : 0);
    checkOutput({tag, " cpu_di"}, 32'(cpu_di), 32'(mDi));
    if (isAcc) checkOutput({tag, " reqHigh"}, reqHigh - highStart, edges);
    releaseBus();
    repeat (2) @(negedge clk);
    checkOutput({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int startCount;
    repeat (2) @(negedge clk);
    checkOutput("rst cpu_di", 32'(cpu_di), 32'hFF);
    checkOutput("rst wait_n", 32'(wait_n), 32'd1);
    checkOutput("rst be_req", 32'(be_req), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst be_addr", 32'(be_addr), 32'd0);
    reset = 1'b0;

    applyStimulus(K_FETCH, 16'h0001, 8'h00, 1, 8'h9E, "memRd");
    applyStimulus(K_MEMWR, 16'hF665, 8'hF3, 3, 8'h00, "memWr");
    applyStimulus(K_IORD,  16'h0010, 8'h00, 1, 8'h5A, "ioRd");
    applyStimulus(K_IOWR,  16'h12AB, 8'h3C, 2, 8'h00, "ioWr");
    applyStimulus(K_MEMRD, 16'h8001, 8'h00, 4, 8'hC3, "memRdSlow");

    // Refresh with rd_n low must still not start a request.
    @(negedge clk);
    startCount = reqCount;
    mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rfsh busy", 32'(busy), 32'd0);
    checkOutput("rfsh reqs", reqCount - startCount, 0);
    releaseBus();

    startCount = reqCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(K_FETCH, 16'h0100 + 16'(i), 8'h00, 1, 8'h00, "nopFetch");
      mreq_n = 1'b0; rfsh_n = 1'b0;
      repeat (2) @(negedge clk);
      releaseBus();
    end
    checkOutput("nopLoop reqs", reqCount - startCount, 10);

    applyStimulus(K_MEMRD, 16'h4000, 8'h00, 0, 8'h00, "timeout");
    applyStimulus(K_INTACK, 16'h0000, 8'h00, 1, 8'h00, "intack");

    // A stray ack while idle must not disturb the held read data.
    startCount = reqCount;
    beRdata = 8'h33;
    strayReq++;
    repeat (4) @(negedge clk);
    checkOutput("strayAck cpu_di", 32'(cpu_di), 32'(mDi));
    checkOutput("strayAck busy", 32'(busy), 32'd0);
    checkOutput("strayAck reqs", reqCount - startCount, 0);

    @(negedge clk);
    beNoAck = 1'b1;
    expQ.push_back('{addr: 16'h2222, we: 1'b0, io: 1'b0, wdata: 8'h00});
    mreq_n = 1'b0; rd_n = 1'b0; A = 16'h2222; cpu_dout = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("preRst busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRst be_req", 32'(be_req), 32'd0);
    checkOutput("midRst wait_n", 32'(wait_n), 32'd1);
    checkOutput("midRst busy", 32'(busy), 32'd0);
    checkOutput("midRst cpu_di", 32'(cpu_di), 32'hFF);
    releaseBus();
    @(negedge clk);
    reset = 1'b0;
    mDi = 8'hFF;
    applyStimulus(K_FETCH, 16'h0000, 8'h00, 1, 8'h3E, "postRst");

    checkOutput("scoreboard empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
